uart_tx: RTL and testbench

- UART transmitter, 8N1, LSB first: the transmit-side counterpart of the core's serial receive path.
- Accepts bytes over a valid/ready handshake into a small FIFO and serializes them onto tx_serial.
- Sits beside the receiver under top. Carries core output, e.g. memory-mapped console writes or debug dumps, back to the host.

---
 rtl/uart_pkg.sv | 15 +
 rtl/tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO buffering bytes between the producer and the UART serializer.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO via valid/ready.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
    logic [BIT_W-1:0]     bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 serial_nxt;
    logic                 baud_done;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] rd_data;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid && tx_ready),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign tx_ready  = !full;
    assign tx_busy   = (state != IDLE) || !empty;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_serial <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            tx_serial <= serial_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift_reg <= shift_nxt;
    end

    // The line level is computed from the next state so tx_serial is a clean flop output.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_idx;
        shift_nxt  = shift_reg;
        pop        = 1'b0;
        serial_nxt = 1'b1;

        if (state != IDLE) begin
            baud_nxt = baud_done ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_nxt = rd_data;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == LAST_BIT) state_nxt = STOP;
                    else                     bit_nxt   = bit_idx + BIT_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_nxt = rd_data;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shift_nxt[0];
            default: serial_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame vectors plus a serial-line decoder scoreboard.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_serial;
    logic             tx_busy;
    logic [CNT_W-1:0] fifo_count;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         rx_count   = 0;
    int         tot_pushed = 0;
    bit         mon_en     = 1'b0;
    bit         saw_full   = 1'b0;
    logic [7:0] exp_q[$];

    // A frame written as 10 line symbols in transmission order: bit i = symbol i.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line decoder: samples mid-bit and compares each byte against what the bench pushed.
    initial begin
        logic [7:0] mb;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_serial === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("mon_start_bit", {31'd0, tx_serial}, 32'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    mb[k] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                check("mon_stop_bit", {31'd0, tx_serial}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_byte", {24'd0, mb}, 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    check("mon_byte", {24'd0, mb}, {24'd0, want});
                end
                rx_count++;
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        for (int t = 0; t < 200 && !done; t++) begin
            if (tx_ready) begin
                check("ready_not_full", {31'd0, fifo_count < DEPTH}, 32'd1);
                exp_q.push_back(b);
                tot_pushed++;
                done = 1'b1;
            end else begin
                saw_full = 1'b1;
                check("ready_low_at_full", {28'd0, fifo_count}, DEPTH);
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [9:0] b2b [3];
        int         peak;

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};
        b2b[0]  = 10'h200;
        b2b[1]  = 10'h3FE;
        b2b[2]  = 10'h2AA;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_ready",  {31'd0, tx_ready},  32'd1);
        check("rst_busy",   {31'd0, tx_busy},   32'd0);
        check("rst_count",  {28'd0, fifo_count}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames from the vector table, including first-byte latency.
        foreach (vecs[v]) begin
            tx_valid = 1'b1;
            tx_data  = vecs[v].data;
            exp_q.push_back(vecs[v].data);
            tot_pushed++;
            @(negedge clk);
            tx_valid = 1'b0;
            check("lat_line_still_idle", {31'd0, tx_serial}, 32'd1);
            check("lat_count_one", {28'd0, fifo_count}, 32'd1);
            for (int i = 0; i < 10 * CPB; i++) begin
                @(negedge clk);
                check($sformatf("frame%0d_sym%0d", v, i / CPB), {31'd0, tx_serial},
                      {31'd0, vecs[v].frame[i / CPB]});
                check("frame_busy", {31'd0, tx_busy}, 32'd1);
            end
            @(negedge clk);
            check("post_frame_idle", {31'd0, tx_serial}, 32'd1);
            check("post_frame_busy", {31'd0, tx_busy}, 32'd0);
            repeat (3) @(negedge clk);
        end

        // Three bytes on consecutive cycles: contiguous frames, occupancy peaks at 2.
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge clk);
        peak    = fifo_count;
        tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 30 * CPB; i++) begin
            @(negedge clk);
            if (fifo_count > peak) peak = fifo_count;
            if (i == 0) begin
                tx_data = 8'h55;
                exp_q.push_back(8'h55);
            end
            if (i == 1) tx_valid = 1'b0;
            check($sformatf("b2b_f%0d_sym%0d", i / (10 * CPB), (i % (10 * CPB)) / CPB),
                  {31'd0, tx_serial}, {31'd0, b2b[i / (10 * CPB)][(i % (10 * CPB)) / CPB]});
        end
        tot_pushed += 3;
        check("b2b_peak_count", peak, 32'd2);
        @(negedge clk);
        check("b2b_idle_after", {31'd0, tx_serial}, 32'd1);
        check("b2b_busy_after", {31'd0, tx_busy}, 32'd0);

        // Reset in the middle of data bit 3 with three bytes still queued.
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'h10 + 8'(i);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_queued", {28'd0, fifo_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("abort_serial", {31'd0, tx_serial}, 32'd1);
        check("abort_count",  {28'd0, fifo_count}, 32'd0);
        check("abort_ready",  {31'd0, tx_ready}, 32'd1);
        check("abort_busy",   {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("abort_no_frame", {31'd0, tx_serial}, 32'd1);
            check("abort_stays_empty", {28'd0, fifo_count}, 32'd0);
        end
        mon_en = 1'b1;

        // Data toggling without valid must not reach the line.
        for (int i = 0; i < 30; i++) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            check("novalid_serial", {31'd0, tx_serial}, 32'd1);
            check("novalid_count", {28'd0, fifo_count}, 32'd0);
        end

        // Held valid: 20 random bytes, then random bytes with gaps, then 0x00..0xFF.
        for (int i = 0; i < 20; i++) send_byte(8'($urandom));
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tx_valid = 1'b0;
                repeat ($urandom_range(1, 60)) @(negedge clk);
            end
        end
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        tx_valid = 1'b0;
        check("saw_full", {31'd0, saw_full}, 32'd1);

        for (int t = 0; t < 2000 && tx_busy; t++) @(negedge clk);
        check("drain_busy", {31'd0, tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
        check("rx_count", rx_count, tot_pushed);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
